// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and helpers: 640x480@60 defaults, an 800x600@60 set,
// and the per-axis segment decode used by both counters.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_POL      = 0;

    // 800x600@60 with a 40 MHz pixel clock; both syncs active-high
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam int SVGA800_POL      = 1;

    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FP     = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BP     = 2'd3
    } axis_seg_e;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic axis_seg_e axis_segment(input int pos, input int active, input int fp,
                                               input int sync);
        axis_seg_e seg;
        if (pos < active) begin
            seg = SEG_ACTIVE;
        end else if (pos < active + fp) begin
            seg = SEG_FP;
        end else if (pos < active + fp + sync) begin
            seg = SEG_SYNC;
        end else begin
            seg = SEG_BP;
        end
        return seg;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter with registered sync and active flags
// decoded from the value being loaded, so flags always match the presented count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA640_H_ACTIVE,
    parameter int FP     = VGA640_H_FP,
    parameter int SYNC   = VGA640_H_SYNC,
    parameter int BP     = VGA640_H_BP,
    parameter int POL    = VGA640_POL,
    parameter int CNT_W  = 11
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int               TOTAL      = total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic             ASSERT_LVL = (POL != 0) ? 1'b1 : 1'b0;

    generate
        if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0 || TOTAL > (1 << CNT_W)) begin : g_bad_param
            $error("vga_axis_counter: zero timing parameter or TOTAL exceeds 2**CNT_W");
        end
    endgenerate

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             sync_r;
    logic             sync_nxt_s;
    logic             active_r;
    logic             active_nxt_s;
    logic             wrap_s;
    axis_seg_e        seg_nxt_s;

    // Next position and wrap detection
    always_comb begin
        wrap_s      = 1'b0;
        count_nxt_s = count_r;
        if (advance) begin
            if (count_r == LAST) begin
                wrap_s      = 1'b1;
                count_nxt_s = {CNT_W{1'b0}};
            end else begin
                count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Decode flags for the position about to be loaded
    always_comb begin
        seg_nxt_s    = axis_segment(int'(count_nxt_s), ACTIVE, FP, SYNC);
        sync_nxt_s   = ~ASSERT_LVL;
        active_nxt_s = 1'b0;
        case (seg_nxt_s)
            SEG_ACTIVE: active_nxt_s = 1'b1;
            SEG_SYNC:   sync_nxt_s   = ASSERT_LVL;
            SEG_FP:     active_nxt_s = 1'b0;
            SEG_BP:     active_nxt_s = 1'b0;
            default: begin
                sync_nxt_s   = ~ASSERT_LVL;
                active_nxt_s = 1'b0;
            end
        endcase
    end

    // Position and flag registers; reset parks one step before the origin
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            count_r  <= LAST;
            sync_r   <= ~ASSERT_LVL;
            active_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            sync_r   <= sync_nxt_s;
            active_r <= active_nxt_s;
        end
    end

    assign count  = count_r;
    assign wrap   = wrap_s;
    assign sync   = sync_r;
    assign active = active_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: chained horizontal/vertical axis counters plus
// the active-video AND and the line/frame strobe registers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int H_SYNC_POL = VGA640_POL,
    parameter int V_SYNC_POL = VGA640_POL,
    parameter int CNT_W      = 11
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             pix_en,
    output logic             Hsync,
    output logic             Vsync,
    output logic [CNT_W-1:0] H_count_value,
    output logic [CNT_W-1:0] V_count_value,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    logic h_wrap_s;
    logic v_wrap_s;
    logic h_active_s;
    logic v_active_s;
    logic line_start_r;
    logic frame_start_r;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(H_SYNC_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk_25MHz(clk_25MHz),
        .reset    (reset),
        .advance  (pix_en),
        .count    (H_count_value),
        .wrap     (h_wrap_s),
        .sync     (Hsync),
        .active   (h_active_s)
    );

    // The vertical axis steps once per completed line
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(V_SYNC_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk_25MHz(clk_25MHz),
        .reset    (reset),
        .advance  (h_wrap_s),
        .count    (V_count_value),
        .wrap     (v_wrap_s),
        .sync     (Vsync),
        .active   (v_active_s)
    );

    // Strobes mark the edge on which the counters land on column 0 / the origin
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
        end
    end

    assign video_on    = h_active_s & v_active_s;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a linear pixel-index model predicts every cycle for a default
// 640x480 instance and a tiny active-high-sync instance that wraps many frames.
module tb_vga_timing_gen;

    localparam int DH_A = 640, DH_F = 16, DH_S = 96, DH_B = 48;
    localparam int DV_A = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
    localparam int DFRAME = (DH_A + DH_F + DH_S + DH_B) * (DV_A + DV_F + DV_S + DV_B);
    localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_A = 5, SV_F = 1, SV_S = 2, SV_B = 2;
    localparam int SFRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

    logic        clk_25MHz = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        d_hs, d_vs, d_vo, d_ls, d_fs;
    logic [10:0] d_h, d_v;
    logic        s_hs, s_vs, s_vo, s_ls, s_fs;
    logic [3:0]  s_h, s_v;

    always #5 clk_25MHz = ~clk_25MHz;

    vga_timing_gen dut_def (
        .clk_25MHz(clk_25MHz), .reset(reset), .pix_en(pix_en),
        .Hsync(d_hs), .Vsync(d_vs), .H_count_value(d_h), .V_count_value(d_v),
        .video_on(d_vo), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CNT_W(4)
    ) dut_small (
        .clk_25MHz(clk_25MHz), .reset(reset), .pix_en(pix_en),
        .Hsync(s_hs), .Vsync(s_vs), .H_count_value(s_h), .V_count_value(s_v),
        .video_on(s_vo), .line_start(s_ls), .frame_start(s_fs)
    );

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit vo;
        bit ls;
        bit fs;
    } exp_t;

    exp_t q_def[$];
    exp_t q_small[$];
    int   total_cnt = 0;
    int   bad_cnt = 0;
    int   p_def = 0;
    int   p_small = 0;
    bit   started = 1'b0;

    // p is the raster position as a linear pixel index within the frame
    function automatic exp_t predict(int p, bit stepped, int ha, int hf, int hs, int hb,
                                     int va, int vf, int vs, bit hp, bit vp);
        exp_t e;
        int   ht;
        ht   = ha + hf + hs + hb;
        e.h  = p % ht;
        e.v  = p / ht;
        e.hs = (e.h >= ha + hf && e.h < ha + hf + hs) ? hp : !hp;
        e.vs = (e.v >= va + vf && e.v < va + vf + vs) ? vp : !vp;
        e.vo = (e.h < ha) && (e.v < va);
        e.ls = stepped && (e.h == 0);
        e.fs = stepped && (p == 0);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            if (bad_cnt <= 30)
                $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit en);
        bit st;
        @(negedge clk_25MHz);
        reset  = r;
        pix_en = en;
        st     = 1'b0;
        if (r) begin
            p_def   = DFRAME - 1;
            p_small = SFRAME - 1;
        end else if (en) begin
            p_def   = (p_def + 1) % DFRAME;
            p_small = (p_small + 1) % SFRAME;
            st      = 1'b1;
        end else begin
            st = 1'b0;
        end
        q_def.push_back(predict(p_def, st, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, 1'b0, 1'b0));
        q_small.push_back(predict(p_small, st, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, 1'b1, 1'b1));
        started = 1'b1;
    endtask

    // Monitor: one expected record per instance after every clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_25MHz);
            #1;
            if (started) begin
                if (q_def.size() == 0 || q_small.size() == 0) begin
                    total_cnt++;
                    bad_cnt++;
                    $display("FAIL scoreboard: got empty queue want a queued record at %0t", $time);
                end else begin
                    e = q_def.pop_front();
                    chk("def_h", 32'(d_h), e.h);
                    chk("def_v", 32'(d_v), e.v);
                    chk("def_hsync", 32'(d_hs), 32'(e.hs));
                    chk("def_vsync", 32'(d_vs), 32'(e.vs));
                    chk("def_video_on", 32'(d_vo), 32'(e.vo));
                    chk("def_line_start", 32'(d_ls), 32'(e.ls));
                    chk("def_frame_start", 32'(d_fs), 32'(e.fs));
                    e = q_small.pop_front();
                    chk("small_h", 32'(s_h), e.h);
                    chk("small_v", 32'(s_v), e.v);
                    chk("small_hsync", 32'(s_hs), 32'(e.hs));
                    chk("small_vsync", 32'(s_vs), 32'(e.vs));
                    chk("small_video_on", 32'(s_vo), 32'(e.vo));
                    chk("small_line_start", 32'(s_ls), 32'(e.ls));
                    chk("small_frame_start", 32'(s_fs), 32'(e.fs));
                end
            end
        end
    end

    initial begin
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        repeat (2000) step(1'b0, 1'b1);
        for (int i = 0; i < 4000; i++) step(1'b0, (i % 4) == 0);
        repeat (3000) step(1'b0, $urandom_range(0, 3) != 0);
        repeat (777) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (20000) step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1);
        repeat (3000) step(1'b0, 1'b1);
        @(posedge clk_25MHz);
        #3;
        total_cnt++;
        if (q_def.size() != 0 || q_small.size() != 0) begin
            bad_cnt++;
            $display("FAIL drain: got %0d records left want 0", q_def.size() + q_small.size());
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
